// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender feeding a 2-entry valid/ready FIFO with a transfer counter
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [1:0] MODE_ZERO   = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             push, pop;
    logic [OUT_W-1:0] zext, sext, ext;

    // Handshake qualifiers come from registered state only, so in_ready never depends on out_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q;
    assign xfer_cnt  = cnt_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign zext = {{(OUT_W-IN_W){1'b0}}, in_data};
    assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

    always_comb begin
        ext = {in_data, {(OUT_W-IN_W){1'b0}}};
        case (in_mode)
            MODE_ZERO:   ext = zext;
            MODE_SIGN:   ext = sext;
            MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
            default:     ext = {in_data, {(OUT_W-IN_W){1'b0}}};
        endcase
    end

    // head_q is always the oldest word; tail_q is only meaningful in FULL.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            if (pop) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = ext;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = ext;
                    end else if (push) begin
                        tail_d  = ext;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] xfer_cnt;

    logic        in_ready_w;
    logic        out_valid_w;
    logic [31:0] out_data_w;
    logic [3:0]  xfer_cnt_w;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .xfer_cnt(xfer_cnt)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_mode(in_mode), .flush(flush),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .xfer_cnt(xfer_cnt_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00;
        flush = 1'b0; out_ready = 1'b0;
        #3;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else n_pass++;
        n_total++;
        if (out_data !== 32'h0 || xfer_cnt !== 16'h0) $display("FAIL reset_data: out_data=%h xfer_cnt=%0d want 0/0", out_data, xfer_cnt);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sign();
        in_valid = 1'b1; in_data = 16'h8000; in_mode = 2'b01; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF8000) $display("FAIL sign_out: valid=%b data=%h want 1/ffff8000", out_valid, out_data);
        else n_pass++;
        step();
        n_total++;
        if (xfer_cnt !== 16'd1 || out_valid !== 1'b0) $display("FAIL sign_cnt: xfer_cnt=%0d valid=%b want 1/0", xfer_cnt, out_valid);
        else n_pass++;
    endtask

    task automatic test_modes();
        logic [15:0] vin  [6] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h4000, 16'h1234};
        logic [1:0]  vmode[6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] vexp [6] = '{32'h00008000, 32'h0000FFFF, 32'h00007FFF, 32'hFFFFFFFC, 32'h00010000, 32'h12340000};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = vin[i]; in_mode = vmode[i]; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            n_total++;
            if (out_valid !== 1'b1 || out_data !== vexp[i]) $display("FAIL mode_%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, vexp[i]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] c0;
        out_ready = 1'b0; in_mode = 2'b01;
        in_valid = 1'b1; in_data = 16'h0001; step();
        in_data = 16'h0002; step();
        n_total++;
        if (in_ready !== 1'b0 || out_data !== 32'h1) $display("FAIL bp_full: in_ready=%b data=%h want 0/00000001", in_ready, out_data);
        else n_pass++;
        c0 = xfer_cnt;
        in_data = 16'h0003; step();
        n_total++;
        if (in_ready !== 1'b0 || out_data !== 32'h1 || xfer_cnt !== c0) $display("FAIL bp_hold: in_ready=%b data=%h cnt=%0d want 0/00000001/%0d", in_ready, out_data, xfer_cnt, c0);
        else n_pass++;
        out_ready = 1'b1; step();
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h2 || in_ready !== 1'b1) $display("FAIL bp_b: valid=%b data=%h in_ready=%b want 1/00000002/1", out_valid, out_data, in_ready);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h3) $display("FAIL bp_c: valid=%b data=%h want 1/00000003", out_valid, out_data);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0 || xfer_cnt !== c0 + 16'd3) $display("FAIL bp_cnt: valid=%b cnt=%0d want 0/%0d", out_valid, xfer_cnt, c0 + 16'd3);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [15:0] c0;
        int bad;
        c0 = xfer_cnt; bad = 0;
        out_ready = 1'b1; in_mode = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h0010 + 16'(i);
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'h10 + 32'(i)) bad++;
        end
        in_valid = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL stream_seq: %0d bad cycles want 0", bad);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0 || xfer_cnt !== c0 + 16'd8) $display("FAIL stream_cnt: valid=%b cnt=%0d want 0/%0d", out_valid, xfer_cnt, c0 + 16'd8);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        out_ready = 1'b0; in_mode = 2'b00; in_valid = 1'b1;
        in_data = 16'h00AA; step();
        in_data = 16'h00BB; step();
        c0 = xfer_cnt;
        in_data = 16'h00CC; out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== c0) $display("FAIL flush_state: valid=%b in_ready=%b cnt=%0d want 0/1/%0d", out_valid, in_ready, xfer_cnt, c0);
        else n_pass++;
        step(); step();
        n_total++;
        if (out_valid !== 1'b0 || xfer_cnt !== c0) $display("FAIL flush_quiet: valid=%b cnt=%0d want 0/%0d", out_valid, xfer_cnt, c0);
        else n_pass++;
        in_valid = 1'b1; in_data = 16'h0055; step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'h55) $display("FAIL flush_resume: valid=%b data=%h want 1/00000055", out_valid, out_data);
        else n_pass++;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_mode = 2'b01; in_valid = 1'b1;
        in_data = 16'h0011; step();
        in_data = 16'h0022; step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || xfer_cnt !== 16'h0 || out_data !== 32'h0)
            $display("FAIL async_rst: valid=%b in_ready=%b cnt=%0d data=%h want 0/1/0/00000000", out_valid, in_ready, xfer_cnt, out_data);
        else n_pass++;
        #1 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 16'h8001; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 32'hFFFF8001) $display("FAIL async_resume: valid=%b data=%h want 1/ffff8001", out_valid, out_data);
        else n_pass++;
        step();
    endtask

    task automatic test_wrap();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        out_ready = 1'b1; in_mode = 2'b00; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 16'h0100 + 16'(i);
            step();
            if (i == 0) begin
                n_total++;
                if (out_valid_w !== 1'b1 || out_data_w !== 32'h100) $display("FAIL wrap_first: valid=%b data=%h want 1/00000100", out_valid_w, out_data_w);
                else n_pass++;
            end
        end
        in_valid = 1'b0;
        step();
        n_total++;
        if (xfer_cnt_w !== 4'd1 || in_ready_w !== 1'b1) $display("FAIL wrap_cnt4: cnt=%0d in_ready=%b want 1/1", xfer_cnt_w, in_ready_w);
        else n_pass++;
        n_total++;
        if (xfer_cnt !== 16'd17) $display("FAIL wrap_cnt16: cnt=%0d want 17", xfer_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sign();
        test_modes();
        test_backpressure();
        test_streaming();
        test_flush();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, is the width of the immediate input field.
REQ-002 Parameter OUT_W, default 32, is the width of the extended output word; legal range is OUT_W >= IN_W+2.
REQ-003 Parameter CNT_W, default 16, is the width of the transfer counter.
REQ-004 One clock and one reset: the block has a single clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port in_valid, input, 1 bit: upstream offers a word.
REQ-008 Port in_ready, output, 1 bit: the block can accept a word.
REQ-009 Port in_data, input, IN_W bits: raw immediate.
REQ-010 Port in_mode, input, 2 bits: extension mode (00 ZERO, 01 SIGN, 10 BRANCH, 11 UPPER).
REQ-011 Port flush, input, 1 bit: synchronous clear of buffered words.
REQ-012 Port out_valid, output, 1 bit: the head word is valid.
REQ-013 Port out_ready, input, 1 bit: downstream accepts the head word.
REQ-014 Port out_data, output, OUT_W bits: extended head word.
REQ-015 Port xfer_cnt, output, CNT_W bits: count of completed output handshakes.

Function
REQ-016 Input handshake: a push occurs on a rising edge with in_valid=1 and in_ready=1; in_data and in_mode are sampled only on a push.
REQ-017 Extension is computed at push time and stored; the buffer holds extended words only.
REQ-018 ZERO mode: out = zeros(OUT_W-IN_W) concatenated with in_data.
REQ-019 SIGN mode: out = in_data[IN_W-1] replicated (OUT_W-IN_W) times, concatenated with in_data.
REQ-020 BRANCH mode: out = (SIGN result) shifted left by 2 and truncated to OUT_W bits; the two LSBs are 0.
REQ-021 UPPER mode: out[OUT_W-1:OUT_W-IN_W] = in_data; all lower bits are 0.
REQ-022 Storage is a 2-entry FIFO; output order equals push order.
REQ-023 Occupancy state machine: EMPTY (0 words), ONE (1 word), FULL (2 words).
REQ-024 State transitions: push only -> +1; pop only -> -1; push and pop together -> unchanged.
REQ-025 in_ready is decoded from registered state only: in_ready = (state != FULL); it has no combinational path from out_ready.
REQ-026 out_valid = (state != EMPTY); out_data = head entry, held stable while out_valid=1 and out_ready=0.
REQ-027 Output handshake: a pop occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-028 Latency: a word pushed on edge N is presented on out_data after edge N when the FIFO was EMPTY (1 cycle).
REQ-029 Throughput: in ONE with in_valid=1 and out_ready=1 continuously, one word is transferred per cycle with no bubbles.
REQ-030 FULL with out_ready=1: pop only; the state goes to ONE and the upstream word waits for in_ready.
REQ-031 Pop while EMPTY is impossible: out_ready is ignored when out_valid=0.
REQ-032 flush=1 on an edge: state goes to EMPTY and any simultaneous push and pop are discarded; flush has priority over both.
REQ-033 xfer_cnt increments by 1 on each pop.
REQ-034 xfer_cnt wraps from 2^CNT_W-1 to 0.
REQ-035 xfer_cnt is not cleared by flush.

Reset
REQ-036 While rst_n=0, the block asynchronously forces: state EMPTY, out_valid 0, in_ready 1, out_data 0, xfer_cnt 0, FIFO storage 0.
REQ-037 Reset assertion mid-transfer discards all buffered words immediately, without waiting for a clock edge.
REQ-038 Operation resumes on the first rising edge after rst_n deasserts.

Verification
REQ-039 SIGN: push 0x8000 into EMPTY with out_ready=1 -> next cycle out_valid=1, out_data=0xFFFF8000, xfer_cnt=1 after the pop edge.
REQ-040 Modes with defaults: ZERO 0x8000 -> 0x00008000; SIGN 0x7FFF -> 0x00007FFF; BRANCH 0xFFFF -> 0xFFFFFFFC; BRANCH 0x4000 -> 0x00010000; UPPER 0x1234 -> 0x12340000.
REQ-041 Backpressure: out_ready=0, push A=0x0001 (SIGN), then B=0x0002 -> in_ready=0 and a third word C is held; raise out_ready -> A, B, C emerge in order; xfer_cnt advances by 3; no word lost or duplicated.
REQ-042 Streaming: 8 consecutive pushes with out_ready=1 -> 8 outputs on 8 consecutive cycles; in_ready stays 1.
REQ-043 Flush while FULL with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1; the flushed and offered words never appear; xfer_cnt is unchanged.
REQ-044 Async reset mid-stream: rst_n pulsed low between clock edges -> out_valid=0 and xfer_cnt=0 immediately; first push after release is output correctly; wrap check with CNT_W=4: 17 pops -> xfer_cnt=1.
